// File: rtl/route_cmd_control.sv
// Multi-stop route command controller: UART command decode, destination FIFO,
// barcode match tracking, motion enable and differential piezo drive.
module route_cmd_control #(
    parameter int ID_W     = 6,
    parameter int DEPTH    = 4,
    parameter int BUZZ_DIV = 12500
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ID_W+1:0]   cmd,
    input  logic              cmd_rdy,
    output logic              clr_cmd_rdy,
    input  logic [ID_W-1:0]   ID,
    input  logic              ID_vld,
    output logic              clr_ID_vld,
    input  logic              OK2Move,
    output logic              in_transit,
    output logic              go,
    output logic              buzz,
    output logic              buzz_n,
    output logic [ID_W-1:0]   dest,
    output logic [$clog2(DEPTH):0] q_cnt,
    output logic              arrived,
    output logic              ovf
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int DW = $clog2(BUZZ_DIV);

    localparam logic [1:0] OP_STOP   = 2'b00;
    localparam logic [1:0] OP_GO     = 2'b01;
    localparam logic [1:0] OP_APPEND = 2'b10;

    typedef enum logic {IDLE, MOVING} state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   mem_q [DEPTH];
    logic [PW-1:0]     rp_q, wp_q;
    logic [CW-1:0]     cnt_q;
    logic              clr_cmd_q, clr_id_q, arrived_q, ovf_q;
    logic              arrived_d, ovf_d;
    logic [DW-1:0]     div_q;
    logic              buzz_q;

    logic              acc_cmd, acc_id, match, flush, push, pop, empty, full, buzz_act;
    logic [1:0]        op;
    logic [ID_W-1:0]   new_id, head;

    assign acc_cmd = cmd_rdy & ~clr_cmd_q;
    assign acc_id  = ID_vld & ~clr_id_q;
    assign op      = cmd[ID_W+1:ID_W];
    assign new_id  = cmd[ID_W-1:0];
    assign head    = mem_q[rp_q];
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == CW'(DEPTH));
    assign match   = acc_id & (state_q == MOVING) & ~empty & (ID == head);

    always_comb begin
        state_d   = state_q;
        flush     = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        ovf_d     = 1'b0;
        arrived_d = 1'b0;
        if (acc_cmd && op == OP_STOP) begin
            flush   = 1'b1;
            state_d = IDLE;
        end else if (acc_cmd && op == OP_GO) begin
            flush   = 1'b1;
            push    = 1'b1;
            state_d = MOVING;
        end else begin
            pop = match;
            // A same-cycle pop frees the slot, so a full queue still takes the append.
            if (acc_cmd && op == OP_APPEND) begin
                if (full && !match) begin
                    ovf_d = 1'b1;
                end else begin
                    push    = 1'b1;
                    state_d = MOVING;
                end
            end
            if (match && cnt_q == CW'(1) && !push) begin
                state_d   = IDLE;
                arrived_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rp_q      <= '0;
            wp_q      <= '0;
            cnt_q     <= '0;
            clr_cmd_q <= 1'b0;
            clr_id_q  <= 1'b0;
            arrived_q <= 1'b0;
            ovf_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            clr_cmd_q <= acc_cmd;
            clr_id_q  <= acc_id;
            arrived_q <= arrived_d;
            ovf_q     <= ovf_d;
            if (flush) begin
                rp_q  <= '0;
                wp_q  <= PW'(push);
                cnt_q <= CW'(push);
                if (push) mem_q[0] <= new_id;
            end else begin
                if (push) begin
                    mem_q[wp_q] <= new_id;
                    wp_q        <= wp_q + PW'(1);
                end
                if (pop) rp_q <= rp_q + PW'(1);
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
            end
        end
    end

    assign buzz_act = (state_q == MOVING) & ~OK2Move;

    // Divider and phase are held at zero whenever the buzzer is inactive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            buzz_q <= 1'b0;
        end else if (!buzz_act) begin
            div_q  <= '0;
            buzz_q <= 1'b0;
        end else if (div_q == DW'(BUZZ_DIV - 1)) begin
            div_q  <= '0;
            buzz_q <= ~buzz_q;
        end else begin
            div_q  <= div_q + DW'(1);
        end
    end

    assign in_transit  = (state_q == MOVING);
    assign go          = in_transit & OK2Move;
    assign buzz        = buzz_act & buzz_q;
    assign buzz_n      = buzz_act & ~buzz_q;
    assign dest        = empty ? '0 : head;
    assign q_cnt       = cnt_q;
    assign clr_cmd_rdy = clr_cmd_q;
    assign clr_ID_vld  = clr_id_q;
    assign arrived     = arrived_q;
    assign ovf         = ovf_q;
endmodule

// File: tb/tb_route_cmd_control.sv
// Bench for route_cmd_control: directed route scenarios plus random traffic,
// all checked against a queue-based route model.
module tb_route_cmd_control;
    localparam int ID_W  = 6;
    localparam int DEPTH = 4;
    localparam int BD    = 4;
    localparam bit [1:0] STOP = 2'd0, GO = 2'd1, APP = 2'd2, RSV = 2'd3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [ID_W+1:0] cmd;
    logic            cmd_rdy;
    logic            clr_cmd_rdy;
    logic [ID_W-1:0] ID;
    logic            ID_vld;
    logic            clr_ID_vld;
    logic            OK2Move;
    logic            in_transit, go, buzz, buzz_n, arrived, ovf;
    logic [ID_W-1:0] dest;
    logic [$clog2(DEPTH):0] q_cnt;

    route_cmd_control #(.ID_W(ID_W), .DEPTH(DEPTH), .BUZZ_DIV(BD)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd), .cmd_rdy(cmd_rdy),
        .clr_cmd_rdy(clr_cmd_rdy), .ID(ID), .ID_vld(ID_vld),
        .clr_ID_vld(clr_ID_vld), .OK2Move(OK2Move), .in_transit(in_transit),
        .go(go), .buzz(buzz), .buzz_n(buzz_n), .dest(dest), .q_cnt(q_cnt),
        .arrived(arrived), .ovf(ovf)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nfail = 0;

    // Route model: destination list, moving flag, expected pulses, active-cycle count
    bit [ID_W-1:0] mq[$];
    bit m_mov, e_clrc, e_clri, e_arr, e_ovf;
    int act_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_mov = 0; e_clrc = 0; e_clri = 0; e_arr = 0; e_ovf = 0; act_cnt = 0;
    endtask

    task automatic model_edge();
        bit acc_c, acc_i, matched;
        bit [1:0] o;
        bit [ID_W-1:0] nid;
        act_cnt = (m_mov && !OK2Move) ? act_cnt + 1 : 0;
        acc_c = cmd_rdy && !e_clrc;
        acc_i = ID_vld && !e_clri;
        o = cmd[ID_W+1:ID_W];
        nid = cmd[ID_W-1:0];
        matched = acc_i && m_mov && mq.size() > 0 && ID == mq[0];
        e_arr = 0; e_ovf = 0;
        if (acc_c && o == STOP) begin
            mq.delete(); m_mov = 0;
        end else if (acc_c && o == GO) begin
            mq.delete(); mq.push_back(nid); m_mov = 1;
        end else begin
            if (matched) void'(mq.pop_front());
            if (acc_c && o == APP) begin
                if (mq.size() < DEPTH) begin mq.push_back(nid); m_mov = 1; end
                else e_ovf = 1;
            end
            if (matched && mq.size() == 0) begin m_mov = 0; e_arr = 1; end
        end
        e_clrc = acc_c;
        e_clri = acc_i;
    endtask

    task automatic check_all();
        bit act, ph;
        act = m_mov && !OK2Move;
        ph  = ((act_cnt / BD) % 2) == 1;
        chk("in_transit", in_transit, m_mov);
        chk("go", go, m_mov && OK2Move);
        chk("buzz", buzz, act && ph);
        chk("buzz_n", buzz_n, act && !ph);
        chk("q_cnt", q_cnt, mq.size());
        chk("dest", dest, mq.size() ? mq[0] : 0);
        chk("clr_cmd_rdy", clr_cmd_rdy, e_clrc);
        chk("clr_ID_vld", clr_ID_vld, e_clri);
        chk("arrived", arrived, e_arr);
        chk("ovf", ovf, e_ovf);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic send(input bit [1:0] o, input bit [ID_W-1:0] id, input int hold);
        cmd = {o, id}; cmd_rdy = 1;
        repeat (hold) tick();
        cmd_rdy = 0;
        tick();
    endtask

    task automatic send_id(input bit [ID_W-1:0] id);
        ID = id; ID_vld = 1;
        tick();
        ID_vld = 0;
        tick();
    endtask

    initial begin
        rst_n = 0; cmd = '0; cmd_rdy = 0; ID = '0; ID_vld = 0; OK2Move = 1;
        model_reset();
        #12;
        chk("rst_in_transit", in_transit, 0);
        chk("rst_q_cnt", q_cnt, 0);
        chk("rst_dest", dest, 0);
        check_all();
        rst_n = 1;

        // Two-stop route with a non-matching read
        send(APP, 6'h05, 1);
        send(APP, 6'h09, 1);
        chk("two_q_cnt", q_cnt, 2);
        chk("two_dest", dest, 6'h05);
        chk("two_transit", in_transit, 1);
        ID = 6'h09; ID_vld = 1; tick();
        chk("nomatch_clr", clr_ID_vld, 1);
        chk("nomatch_q", q_cnt, 2);
        ID_vld = 0; tick();
        send_id(6'h05);
        chk("pop_dest", dest, 6'h09);
        chk("pop_q", q_cnt, 1);
        ID = 6'h09; ID_vld = 1; tick();
        chk("arrive_pulse", arrived, 1);
        chk("arrive_idle", in_transit, 0);
        ID_vld = 0; tick();
        chk("arrive_end", arrived, 0);

        // Overflow, then append + pop on a full queue with pointer wrap
        for (int i = 1; i <= 4; i++) send(APP, 6'(i), 1);
        chk("full_q", q_cnt, 4);
        cmd = {APP, 6'h3F}; cmd_rdy = 1; tick();
        chk("ovf_pulse", ovf, 1);
        chk("ovf_q", q_cnt, 4);
        cmd_rdy = 0; tick();
        cmd = {APP, 6'h3F}; cmd_rdy = 1; ID = 6'h01; ID_vld = 1; tick();
        chk("swap_q", q_cnt, 4);
        chk("swap_dest", dest, 6'h02);
        chk("swap_ovf", ovf, 0);
        cmd_rdy = 0; ID_vld = 0; tick();
        send_id(6'h02); send_id(6'h03); send_id(6'h04);
        chk("wrap_dest", dest, 6'h3F);
        send_id(6'h3F);
        chk("wrap_done", in_transit, 0);

        // GO replaces the route, STOP aborts without arrival
        send(GO, 6'h10, 1); send(APP, 6'h11, 1); send(APP, 6'h12, 1);
        chk("three_q", q_cnt, 3);
        send(GO, 6'h2A, 1);
        chk("go_q", q_cnt, 1);
        chk("go_dest", dest, 6'h2A);
        cmd = {STOP, 6'h00}; cmd_rdy = 1; tick();
        chk("stop_transit", in_transit, 0);
        chk("stop_dest", dest, 0);
        chk("stop_arrived", arrived, 0);
        cmd_rdy = 0; tick();

        // Buzzer while blocked
        send(APP, 6'h15, 1);
        OK2Move = 0; #1;
        chk("blk_go", go, 0);
        repeat (3) tick();
        chk("bz_pre", buzz, 0);
        chk("bzn_pre", buzz_n, 1);
        tick();
        chk("bz_t1", buzz, 1);
        chk("bzn_t1", buzz_n, 0);
        repeat (3) tick();
        chk("bz_hold", buzz, 1);
        tick();
        chk("bz_t2", buzz, 0);
        repeat (3) tick();
        OK2Move = 1; #1;
        chk("clr_go", go, 1);
        chk("clr_bz", buzz, 0);
        chk("clr_bzn", buzz_n, 0);
        send(STOP, 6'h00, 1);

        // Handshake: command held two cycles, ID in IDLE, reserved opcode
        cmd = {APP, 6'h08}; cmd_rdy = 1; tick();
        chk("hold_clr1", clr_cmd_rdy, 1);
        tick();
        chk("hold_clr2", clr_cmd_rdy, 0);
        chk("hold_q", q_cnt, 1);
        cmd_rdy = 0; tick();
        send(STOP, 6'h00, 1);
        ID = 6'h08; ID_vld = 1; tick();
        chk("idle_id_clr", clr_ID_vld, 1);
        chk("idle_id_state", in_transit, 0);
        ID_vld = 0; tick();
        cmd = {RSV, 6'h03}; cmd_rdy = 1; tick();
        chk("rsv_clr", clr_cmd_rdy, 1);
        chk("rsv_q", q_cnt, 0);
        cmd_rdy = 0; tick();

        // Asynchronous reset mid-route with buzzer sounding
        send(APP, 6'h01, 1); send(APP, 6'h02, 1); send(APP, 6'h03, 1);
        OK2Move = 0;
        repeat (5) tick();
        chk("pre_rst_bz", buzz, 1);
        #2 rst_n = 0;
        #1;
        model_reset();
        chk("mrst_transit", in_transit, 0);
        chk("mrst_buzz", buzz, 0);
        chk("mrst_buzzn", buzz_n, 0);
        chk("mrst_q", q_cnt, 0);
        chk("mrst_dest", dest, 0);
        check_all();
        #2 rst_n = 1;
        OK2Move = 1;
        send(GO, 6'h07, 1);
        chk("post_rst_q", q_cnt, 1);
        send(STOP, 6'h00, 1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            int r;
            bit dc, di;
            r  = $urandom_range(0, 9);
            dc = $urandom_range(0, 2) != 0;
            di = $urandom_range(0, 2) != 0;
            OK2Move = $urandom_range(0, 9) < 7;
            cmd = {(r < 1) ? STOP : (r < 2) ? GO : (r < 3) ? RSV : APP,
                   6'($urandom_range(0, 63))};
            ID = ($urandom_range(0, 1) && mq.size() > 0) ? mq[0] : 6'($urandom_range(0, 63));
            cmd_rdy = dc; ID_vld = di;
            tick();
            if ($urandom_range(0, 3) == 0) tick();
            cmd_rdy = 0; ID_vld = 0;
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end
endmodule

// File: doc/route_cmd_control.md
# route_cmd_control

Command controller for the follower robot that supports multi-stop routes. It accepts 8-bit style UART commands (width set by parameter) and keeps a FIFO queue of destination IDs. It tracks barcode ID reads against the queue head and drives the motion enable and a tone-generating differential piezo buzzer. It sits between the UART command receiver and barcode reader on one side and the motion controller and piezo on the other.

## Interface
- ID_W, 6: destination/barcode ID width; command word is ID_W+2 bits.
- DEPTH, 4: destination queue depth; power of two, ≥2.
- BUZZ_DIV, 12500: buzzer half-period in clk cycles; ≥2.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd  in  ID_W+2  command: [ID_W+1:ID_W] opcode, [ID_W-1:0] destination ID
- cmd_rdy  in  1  cmd valid, held until cleared
- clr_cmd_rdy  out  1  one-cycle pulse: command consumed
- ID  in  ID_W  barcode ID read
- ID_vld  in  1  ID valid, held until cleared
- clr_ID_vld  out  1  one-cycle pulse: ID consumed
- OK2Move  in  1  obstacle-free indication
- in_transit  out  1  FSM in MOVING
- go  out  1  motion enable
- buzz, buzz_n  out  1 each  differential piezo drive
- dest  out  ID_W  current queue head, 0 when empty
- q_cnt  out  $clog2(DEPTH)+1  entries queued
- arrived  out  1  one-cycle pulse when the final destination is reached
- ovf  out  1  one-cycle pulse when an APPEND is dropped

## Operation
- Opcodes: 00 STOP, 01 GO, 10 APPEND, 11 reserved. A reserved command is consumed and ignored.
- Command accepted when cmd_rdy & ~clr_cmd_rdy. Every accepted command produces a clr_cmd_rdy pulse.
- ID accepted when ID_vld & ~clr_ID_vld. Every accepted ID produces a clr_ID_vld pulse, in any state and whether or not it matches.
- States: IDLE and MOVING. in_transit = (state==MOVING).
- IDLE:
  - GO: flush queue, push ID, go to MOVING.
  - APPEND: push ID, go to MOVING.
  - STOP: flush queue.
  - An accepted ID is discarded.
- MOVING:
  - STOP: flush queue, go to IDLE.
  - GO: flush queue, push the new ID as sole entry, stay in MOVING.
  - APPEND: push if q_cnt<DEPTH. If the queue is full, drop the entry and pulse ovf.
  - ID == dest: pop. If the queue becomes empty, go to IDLE and pulse arrived. Otherwise stay in MOVING; dest becomes the next entry.
  - ID != dest: no state change.
- Simultaneous command and ID in one cycle:
  - STOP or GO takes precedence; the ID is consumed with no match action.
  - APPEND + matching ID: push and pop in the same cycle. q_cnt is unchanged; dest advances.
  - An APPEND that hits a full queue while a matching ID arrives in the same cycle is accepted, because the pop frees a slot.
  - An APPEND + matching ID on a single-entry queue stays in MOVING; arrived is not pulsed.
- Queue: circular buffer with wrapping read/write pointers (mod DEPTH). q_cnt ranges 0..DEPTH. Flush resets the pointers and q_cnt to 0.
- go = in_transit & OK2Move (combinational).
- Buzzer: active when in_transit & ~OK2Move.
  - While active, buzz toggles every BUZZ_DIV cycles and buzz_n = ~buzz.
  - While inactive, buzz = buzz_n = 0 and the divider counter is held at 0.
  - First toggle occurs BUZZ_DIV cycles after activation.

## Timing
- Reset values: state IDLE; queue empty; in_transit, go, buzz, buzz_n, clr_cmd_rdy, clr_ID_vld, arrived, ovf, q_cnt, dest all 0; divider counter 0.
- Reset mid-route clears everything immediately and asynchronously.
- A command accepted at edge N updates in_transit, q_cnt, dest, clr_cmd_rdy, and ovf at edge N. That is one cycle of latency, with clr_cmd_rdy high for cycle N..N+1 only.
- A matching ID accepted at edge N updates q_cnt, dest, and in_transit and pulses clr_ID_vld and arrived at edge N.
- A source that keeps cmd_rdy/ID_vld high one extra cycle after the clear pulse is not double-counted. A source held longer re-issues the command.
- go follows OK2Move with zero latency.
- buzz period = 2·BUZZ_DIV cycles.

## Test plan
- Reset, then APPEND 0x05, APPEND 0x09 (ID_W=6) -> in_transit=1, q_cnt=2, dest=0x05. ID 0x09 -> clr_ID_vld pulse, no change. ID 0x05 -> dest=0x09, q_cnt=1. ID 0x09 -> arrived pulse, in_transit=0, q_cnt=0.
- Fill with DEPTH=4 APPENDs (0x01..0x04), then APPEND 0x3F -> ovf pulse, q_cnt stays 4. Then ID 0x01 together with APPEND 0x3F -> q_cnt=4 and the final entry is 0x3F; pops through 0x02..0x04 then 0x3F, confirming pointer wrap.
- While moving with 3 entries, GO 0x2A -> q_cnt=1, dest=0x2A. STOP -> in_transit=0, q_cnt=0, dest=0, no arrived pulse.
- In MOVING with OK2Move=0, BUZZ_DIV=4 -> go=0; buzz toggles every 4 cycles with buzz_n=~buzz. OK2Move=1 -> go=1, buzz=buzz_n=0 the same cycle.
- cmd_rdy held 2 cycles, and ID_vld in IDLE -> exactly one clr_cmd_rdy pulse; the ID is consumed and discarded; opcode 11 -> clr pulse only.
- Assert rst_n low mid-route with 3 queued entries and buzzer active -> all outputs 0 immediately. After release, a new GO 0x07 gives q_cnt=1.
